// File: rtl/clint_mh_if.sv
// Request/response bus between a bus master and the clint_mh register block.
// Signal names keep the block's port naming so the master sees the same names.
interface clint_mh_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              req_valid_i;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [31:0]       req_wdata_i;
  logic [3:0]        req_wstrb_i;
  logic              req_ready_o;
  logic              resp_valid_o;
  logic [31:0]       resp_rdata_o;
  logic              resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: prescaled 64-bit mtime, per-hart mtimecmp/msip.
// CLINT_MTIME_HI_LATCH_EN: mtime hi reads return the hi half captured by the last lo read.
module clint_mh #(
  parameter int unsigned NUM_HARTS = 1,
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  clint_mh_if.slave            bus,
  output logic [NUM_HARTS-1:0] mtip_o,
  output logic [NUM_HARTS-1:0] msip_o,
  output logic [63:0]          mtime_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  logic [PW-1:0]        presc_q, presc_d;
  logic                 tick;
  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          cmp_q [NUM_HARTS];
  logic [63:0]          cmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, msip_d, mtip_q, mtip_d;
  logic                 resp_valid_q, resp_err_q;
  logic [31:0]          resp_rdata_q, rdata;
  logic [ADDR_W-1:0]    addr_raw;
  logic [31:0]          addr;
  logic                 aligned, msip_hit, cmp_hit, lo_hit, hi_hit, hit, wr, rd;

`ifdef CLINT_MTIME_HI_LATCH_EN
  logic [31:0] shadow_q, shadow_d;
`endif

  assign addr_raw = bus.req_addr_i;

  always_comb begin
    addr     = 32'(addr_raw);
    aligned  = (addr[1:0] == 2'b00);
    msip_hit = aligned && (addr < 32'(4 * NUM_HARTS));
    cmp_hit  = aligned && (addr >= 32'h4000) && (addr < 32'h4000 + 32'(8 * NUM_HARTS));
    lo_hit   = (addr == 32'hBFF8);
    hi_hit   = (addr == 32'hBFFC);
    hit      = msip_hit || cmp_hit || lo_hit || hi_hit;
    wr       = bus.req_valid_i && bus.req_we_i && hit;
    rd       = bus.req_valid_i && !bus.req_we_i && hit;
  end

  always_comb begin
    tick    = (presc_q == PrescMax);
    presc_d = tick ? '0 : presc_q + 1'b1;
    // A bus write to either half replaces the tick for that cycle: no carry.
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    msip_d  = msip_q;
    cmp_d   = cmp_q;
    rdata   = '0;
    if (wr && lo_hit) mtime_d = {mtime_q[63:32],
                                 merge_bytes(mtime_q[31:0], bus.req_wdata_i, bus.req_wstrb_i)};
    if (wr && hi_hit) mtime_d = {merge_bytes(mtime_q[63:32], bus.req_wdata_i, bus.req_wstrb_i),
                                 mtime_q[31:0]};
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      mtip_d[h] = (mtime_q >= cmp_q[h]);
      if (msip_hit && addr[4:2] == 3'(h)) begin
        if (wr && bus.req_wstrb_i[0]) msip_d[h] = bus.req_wdata_i[0];
        rdata = {31'b0, msip_q[h]};
      end
      if (cmp_hit && addr[5:3] == 3'(h)) begin
        if (wr && addr[2]) begin
          cmp_d[h][63:32] = merge_bytes(cmp_q[h][63:32], bus.req_wdata_i, bus.req_wstrb_i);
        end else if (wr) begin
          cmp_d[h][31:0] = merge_bytes(cmp_q[h][31:0], bus.req_wdata_i, bus.req_wstrb_i);
        end
        rdata = addr[2] ? cmp_q[h][63:32] : cmp_q[h][31:0];
      end
    end
    if (lo_hit) rdata = mtime_q[31:0];
`ifdef CLINT_MTIME_HI_LATCH_EN
    if (hi_hit) rdata = shadow_q;
    shadow_d = shadow_q;
    if (rd && lo_hit) shadow_d = mtime_q[63:32];
    if (wr && (lo_hit || hi_hit)) shadow_d = mtime_d[63:32];
`else
    if (hi_hit) rdata = mtime_q[63:32];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      mtime_q      <= '0;
      msip_q       <= '0;
      mtip_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) cmp_q[h] <= '1;
    end else begin
      presc_q      <= presc_d;
      mtime_q      <= mtime_d;
      msip_q       <= msip_d;
      mtip_q       <= mtip_d;
      cmp_q        <= cmp_d;
      resp_valid_q <= bus.req_valid_i;
      resp_err_q   <= bus.req_valid_i && !hit;
      resp_rdata_q <= rd ? rdata : '0;
    end
  end

`ifdef CLINT_MTIME_HI_LATCH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end
`endif

  assign bus.req_ready_o  = ~rst;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.resp_rdata_o = resp_rdata_q;
  assign mtip_o           = mtip_q;
  assign msip_o           = msip_q;
  assign mtime_o          = mtime_q;

endmodule

// File: tb/tb_clint_mh.sv
// Bench for clint_mh: randomized bus traffic against a closed-form mtime model
// (value = written base + number of prescaler wraps since the write).
module tb_clint_mh;
  localparam int unsigned NH = 2;
  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clint_mh_if #(.ADDR_W(16)) bif ();
  clint_mh_if #(.ADDR_W(16)) bif1 ();
  logic [NH-1:0] mtip, msip;
  logic [63:0]   mtime;
  logic [0:0]    mtip1, msip1;
  logic [63:0]   mtime1;

  clint_mh #(.NUM_HARTS(NH), .TICK_DIV(TD), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bif), .mtip_o(mtip), .msip_o(msip), .mtime_o(mtime)
  );
  clint_mh #(.NUM_HARTS(1), .TICK_DIV(1), .ADDR_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bif1), .mtip_o(mtip1), .msip_o(msip1), .mtime_o(mtime1)
  );

  int vectors = 0;
  int miscompares = 0;
  longint unsigned cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // mtime model: ticks fall on cycles k with k % TD == TD-1, counted from base_cyc.
  logic [63:0]     base_val;
  longint unsigned base_cyc;
  logic [31:0]     shadow_m;

  function automatic logic [63:0] mt(input longint unsigned k);
    return base_val + 64'(k / TD) - 64'(base_cyc / TD);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic void model_mt_write(input longint unsigned acc, input logic hi,
                                         input logic [31:0] wd, input logic [3:0] st);
    logic [63:0] cur;
    cur = mt(acc);
    if (hi) cur[63:32] = merge(cur[63:32], wd, st);
    else    cur[31:0]  = merge(cur[31:0], wd, st);
    base_val = cur;
    base_cyc = acc + 1;
    shadow_m = cur[63:32];
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    bif.req_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    base_val = '0; base_cyc = 0; shadow_m = '0;
    #1;
  endtask

  task automatic bus_xfer(input logic we, input logic [15:0] a, input logic [31:0] wd,
                          input logic [3:0] st, output longint unsigned acc, output logic v,
                          output logic [31:0] rd, output logic e);
    bif.req_valid_i = 1'b1; bif.req_we_i = we; bif.req_addr_i = a;
    bif.req_wdata_i = wd;   bif.req_wstrb_i = st;
    acc = cyc;
    @(posedge clk); #1;
    v = bif.resp_valid_o; rd = bif.resp_rdata_o; e = bif.resp_err_o;
    bif.req_valid_i = 1'b0; bif.req_we_i = 1'b0;
  endtask

  task automatic test_reset();
    longint unsigned acc; logic v, e; logic [31:0] rd;
    logic [15:0] ra [3] = '{16'h4000, 16'h4004, 16'h0000};
    logic [31:0] rx [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bif.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL ready_in_rst: got %b want 0", bif.req_ready_o); end
    vectors++; if (bif.resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL valid_in_rst: got %b want 0", bif.resp_valid_o); end
    vectors++; if (mtime !== 64'd0) begin miscompares++; $display("FAIL mtime_rst: got %h want 0", mtime); end
    @(posedge clk); #1;
    rst = 1'b0; base_val = '0; base_cyc = 0; shadow_m = '0;
    #1;
    vectors++; if (bif.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL ready_after_rst: got %b want 1", bif.req_ready_o); end
    for (int i = 0; i < 3; i++) begin
      bus_xfer(1'b0, ra[i], 32'h0, 4'h0, acc, v, rd, e);
      vectors++; if (v !== 1'b1 || e !== 1'b0) begin miscompares++; $display("FAIL rst_read_resp %h: got v=%b e=%b want v=1 e=0", ra[i], v, e); end
      vectors++; if (rd !== rx[i]) begin miscompares++; $display("FAIL rst_read %h: got %h want %h", ra[i], rd, rx[i]); end
    end
    vectors++; if (mtip !== '0 || msip !== '0) begin miscompares++; $display("FAIL rst_irq: got mtip=%b msip=%b want 0 0", mtip, msip); end
  endtask

  task automatic test_prescaler();
    longint unsigned acc; logic v, e; logic [31:0] rd;
    do_reset();
    idle($urandom_range(30, 50));
    bus_xfer(1'b0, 16'hBFF8, 32'h0, 4'h0, acc, v, rd, e);
    vectors++; if (rd !== mt(acc)[31:0] || v !== 1'b1) begin miscompares++; $display("FAIL mtime_lo_read: got %h want %h", rd, mt(acc)[31:0]); end
    for (int i = 0; i < 16; i++) begin
      vectors++; if (mtime !== mt(cyc)) begin miscompares++; $display("FAIL mtime_step: got %h want %h", mtime, mt(cyc)); end
      vectors++; if (mtime1 !== 64'(cyc)) begin miscompares++; $display("FAIL mtime_div1: got %h want %h", mtime1, 64'(cyc)); end
      idle(1);
    end
  endtask

  task automatic test_mtip();
    longint unsigned acc; logic v, e; logic [31:0] rd; logic [63:0] cmp1;
    int tgt;
    do_reset();
    tgt = $urandom_range(10, 20);
    cmp1 = 64'(tgt);
    bus_xfer(1'b1, 16'h400C, 32'h0, 4'hF, acc, v, rd, e);
    bus_xfer(1'b1, 16'h4008, 32'(tgt), 4'hF, acc, v, rd, e);
    idle(1);
    for (int i = 0; i < tgt * TD + 8; i++) begin
      vectors++; if (mtip[1] !== (mt(cyc - 1) >= cmp1)) begin miscompares++; $display("FAIL mtip1 cyc %0d: got %b want %b", cyc, mtip[1], mt(cyc - 1) >= cmp1); end
      vectors++; if (mtip[0] !== 1'b0) begin miscompares++; $display("FAIL mtip0: got %b want 0", mtip[0]); end
      idle(1);
    end
    vectors++; if (mtip[1] !== 1'b1) begin miscompares++; $display("FAIL mtip_rise: got %b want 1", mtip[1]); end
    bus_xfer(1'b1, 16'h400C, 32'h1, 4'hF, acc, v, rd, e);
    vectors++; if (mtip[1] !== 1'b1) begin miscompares++; $display("FAIL mtip_hold: got %b want 1", mtip[1]); end
    idle(1);
    vectors++; if (mtip[1] !== 1'b0) begin miscompares++; $display("FAIL mtip_clear: got %b want 0", mtip[1]); end
  endtask

  task automatic test_msip();
    longint unsigned acc; logic v, e; logic [31:0] rd, d;
    do_reset();
    d = $urandom | 32'h1;
    bus_xfer(1'b1, 16'h0004, d, 4'hF, acc, v, rd, e);
    vectors++; if (v !== 1'b1 || e !== 1'b0 || rd !== 32'h0) begin miscompares++; $display("FAIL msip_wr_resp: got v=%b e=%b rd=%h want 1 0 0", v, e, rd); end
    bus_xfer(1'b0, 16'h0004, 32'h0, 4'h0, acc, v, rd, e);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL msip_readback: got %h want 1", rd); end
    vectors++; if (msip !== 2'b10) begin miscompares++; $display("FAIL msip_set: got %b want 10", msip); end
    bus_xfer(1'b1, 16'h0004, 32'h0, 4'b1110, acc, v, rd, e);
    idle(1);
    vectors++; if (msip !== 2'b10) begin miscompares++; $display("FAIL msip_strb: got %b want 10", msip); end
    bus_xfer(1'b1, 16'h0004, $urandom & 32'hFFFF_FFFE, 4'hF, acc, v, rd, e);
    idle(1);
    vectors++; if (msip !== 2'b00) begin miscompares++; $display("FAIL msip_clear: got %b want 00", msip); end
  endtask

  task automatic test_cmp_rw();
    longint unsigned acc; logic v, e; logic [31:0] rd, wd; logic [3:0] st;
    logic [31:0] cm [4] = '{default: 32'hFFFF_FFFF};
    int j;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      j = $urandom_range(0, 3);
      wd = $urandom; st = 4'($urandom);
      cm[j] = merge(cm[j], wd, st);
      bus_xfer(1'b1, 16'h4000 + 16'(4 * j), wd, st, acc, v, rd, e);
      bus_xfer(1'b0, 16'h4000 + 16'(4 * j), 32'h0, 4'h0, acc, v, rd, e);
      vectors++; if (rd !== cm[j] || e !== 1'b0) begin miscompares++; $display("FAIL cmp_rw[%0d]: got %h err %b want %h", j, rd, e, cm[j]); end
    end
  endtask

  task automatic test_mtime_carry();
    longint unsigned acc; logic v, e; logic [31:0] rd, exp_hi, wd; logic [3:0] st;
    int guard;
    do_reset();
    bus_xfer(1'b1, 16'hBFFC, 32'h0, 4'hF, acc, v, rd, e); model_mt_write(acc, 1'b1, 32'h0, 4'hF);
    bus_xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, acc, v, rd, e);
    model_mt_write(acc, 1'b0, 32'hFFFF_FFFE, 4'hF);
    guard = 0;
    while (mtime !== 64'h0_FFFF_FFFF && guard < 20) begin idle(1); guard++; end
    vectors++; if (mtime !== 64'h0_FFFF_FFFF) begin miscompares++; $display("FAIL mtime_pre_carry: got %h want 0ffffffff", mtime); end
    bus_xfer(1'b0, 16'hBFF8, 32'h0, 4'h0, acc, v, rd, e);
    shadow_m = mt(acc)[63:32];
    vectors++; if (rd !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL lo_before_carry: got %h want ffffffff", rd); end
    guard = 0;
    while (mtime !== 64'h1_0000_0000 && guard < 20) begin idle(1); guard++; end
    vectors++; if (mtime !== 64'h1_0000_0000) begin miscompares++; $display("FAIL mtime_carry: got %h want 100000000", mtime); end
    for (int i = 0; i < 2; i++) begin
      bus_xfer(1'b0, 16'hBFFC, 32'h0, 4'h0, acc, v, rd, e);
`ifdef CLINT_MTIME_HI_LATCH_EN
      exp_hi = shadow_m;
`else
      exp_hi = mt(acc)[63:32];
`endif
      vectors++; if (rd !== exp_hi) begin miscompares++; $display("FAIL hi_read%0d: got %h want %h", i, rd, exp_hi); end
      bus_xfer(1'b0, 16'hBFF8, 32'h0, 4'h0, acc, v, rd, e);
      shadow_m = mt(acc)[63:32];
      vectors++; if (rd !== mt(acc)[31:0]) begin miscompares++; $display("FAIL lo_read%0d: got %h want %h", i, rd, mt(acc)[31:0]); end
    end
    for (int i = 0; i < 2; i++) begin
      guard = 0;
      while (cyc % TD != TD - 1 && guard < 8) begin idle(1); guard++; end
      wd = $urandom; st = (i == 0) ? 4'hF : 4'($urandom);
      bus_xfer(1'b1, (i == 0) ? 16'hBFFC : 16'hBFF8, wd, st, acc, v, rd, e);
      model_mt_write(acc, i == 0, wd, st);
      for (int k = 0; k < 8; k++) begin
        vectors++; if (mtime !== mt(cyc)) begin miscompares++; $display("FAIL mtime_wr_tick%0d: got %h want %h", i, mtime, mt(cyc)); end
        idle(1);
      end
    end
  endtask

  task automatic test_error();
    longint unsigned acc; logic v, e; logic [31:0] rd;
    logic [15:0] ea [9] = '{16'h0010, 16'h4002, 16'h4010, 16'h8000, 16'hBFFA,
                            16'h0010, 16'h4006, 16'hBFF9, 16'h000C};
    logic        ew [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    bus_xfer(1'b1, 16'h0004, 32'h1, 4'hF, acc, v, rd, e);
    for (int i = 0; i < 9; i++) begin
      bus_xfer(ew[i], ea[i], (i == 6) ? 32'h0 : 32'hFFFF_FFFF, 4'hF, acc, v, rd, e);
      vectors++; if (v !== 1'b1 || e !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL err %h: got v=%b e=%b rd=%h want 1 1 0", ea[i], v, e, rd); end
    end
    idle(1);
    vectors++; if (msip !== 2'b10) begin miscompares++; $display("FAIL err_msip_kept: got %b want 10", msip); end
    vectors++; if (mtime !== mt(cyc)) begin miscompares++; $display("FAIL err_mtime_kept: got %h want %h", mtime, mt(cyc)); end
    bus_xfer(1'b0, 16'h4004, 32'h0, 4'h0, acc, v, rd, e);
    vectors++; if (rd !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL err_cmp_kept: got %h want ffffffff", rd); end
  endtask

  task automatic test_back_to_back();
    longint unsigned a0, a1, a2; logic v, e; logic [31:0] rd, x, y;
    do_reset();
    x = $urandom; y = $urandom;
    bus_xfer(1'b1, 16'h4000, x, 4'hF, a0, v, rd, e);
    bus_xfer(1'b0, 16'h4000, 32'h0, 4'h0, a1, v, rd, e);
    vectors++; if (v !== 1'b1 || rd !== x || a1 != a0 + 1) begin miscompares++; $display("FAIL b2b_wr_rd: got v=%b rd=%h want 1 %h", v, rd, x); end
    bus_xfer(1'b0, 16'hBFF8, 32'h0, 4'h0, a2, v, rd, e);
    vectors++; if (v !== 1'b1 || rd !== mt(a2)[31:0]) begin miscompares++; $display("FAIL b2b_mtime: got v=%b rd=%h want 1 %h", v, rd, mt(a2)[31:0]); end
    bus_xfer(1'b1, 16'h4004, y, 4'hF, a0, v, rd, e);
    bus_xfer(1'b0, 16'h4004, 32'h0, 4'h0, a1, v, rd, e);
    vectors++; if (v !== 1'b1 || rd !== y) begin miscompares++; $display("FAIL b2b_hi: got v=%b rd=%h want 1 %h", v, rd, y); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bif.req_valid_i = 1'b1; bif.req_we_i = 1'b0; bif.req_addr_i = 16'h4000;
    @(posedge clk); #1;
    vectors++; if (bif.resp_valid_o !== 1'b1) begin miscompares++; $display("FAIL mid_resp: got %b want 1", bif.resp_valid_o); end
    rst = 1'b1;
    #1;
    vectors++; if (bif.resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", bif.resp_valid_o); end
    vectors++; if (bif.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready: got %b want 0", bif.req_ready_o); end
    bif.req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bif.req_valid_i = 1'b0; bif.req_we_i = 1'b0; bif.req_addr_i = '0;
    bif.req_wdata_i = '0;   bif.req_wstrb_i = '0;
    bif1.req_valid_i = 1'b0; bif1.req_we_i = 1'b0; bif1.req_addr_i = '0;
    bif1.req_wdata_i = '0;   bif1.req_wstrb_i = '0;
    base_val = '0; base_cyc = 0; shadow_m = '0;
    test_reset();
    test_prescaler();
    test_mtip();
    test_msip();
    test_cmp_rw();
    test_mtime_carry();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clint_mh.md
Name: clint_mh

Overview:
- Parametrised core-local interruptor; successor to the single-timer CLINT datapath.
- Holds a 64-bit mtime with prescaler, plus per-hart mtimecmp and msip registers.
- Uses a 32-bit valid/response memory-mapped bus.
- Drives per-hart machine timer (mtip) and software (msip) interrupt lines into each hart's trap logic, and exports mtime for the time/timeh CSRs.

Parameters:
NUM_HARTS, 1, number of harts served (1..8)
TICK_DIV, 1, clk cycles per mtime increment (>=1)
ADDR_W, 16, bus offset width (byte address within CLINT window)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid_i  in  1  bus request strobe
req_we_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_W  byte offset, word aligned
req_wdata_i  in  32  write data
req_wstrb_i  in  4  byte enables
req_ready_o  out  1  request accept
resp_valid_o  out  1  response strobe
resp_rdata_o  out  32  read data
resp_err_o  out  1  unmapped or misaligned access
mtip_o  out  NUM_HARTS  per-hart timer interrupt pending
msip_o  out  NUM_HARTS  per-hart software interrupt pending
mtime_o  out  64  current mtime

Behaviour:
- Clock and reset: one clock `clk`; asynchronous active-high reset `rst`.
- Reset values:
  - mtime=0, prescaler=0.
  - mtimecmp[h]=64'hFFFF_FFFF_FFFF_FFFF.
  - msip[h]=0, mtip_o=0.
  - resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
  - req_ready_o=1 after reset, 0 while rst asserted.
- Address map (offsets):
  - msip[h] at 0x0000+4h; only bit0 is writable, other bits read 0.
  - mtimecmp[h] lo at 0x4000+8h, hi at 0x4004+8h.
  - mtime lo at 0xBFF8, hi at 0xBFFC.
  - Any other offset, any hart index >= NUM_HARTS, or addr[1:0]!=0 gives an error response.
- Handshake:
  - req_ready_o is always 1 out of reset; a request is accepted in every cycle req_valid_i=1.
  - resp_valid_o pulses exactly 1 cycle after acceptance, carrying read data, or 0 for writes.
  - Back-to-back requests give back-to-back responses; no outstanding limit.
  - Error: resp_err_o=1, rdata=0, no state change.
- Writes: byte-merged per req_wstrb_i; a write becomes visible on the response cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1; mtime += 1 on the cycle the prescaler wraps.
  - With TICK_DIV=1, mtime increments every cycle.
- mtime arithmetic: 64-bit unsigned, wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
- Simultaneous bus write to mtime lo/hi and a tick:
  - The write wins for the written half.
  - The other half holds; no carry is applied that cycle.
  - The prescaler keeps counting.
- Interrupts:
  - mtip_o[h] is registered: (mtime >= mtimecmp[h]) evaluated on current register values, asserted the cycle after the condition first holds.
  - A mtimecmp write that makes the condition false clears mtip_o[h] the cycle after the write.
  - msip_o[h] = msip[h] bit0, registered.
- Reads of mtime: return the pre-increment value of the acceptance cycle.
- Reset mid-operation: any pending response is dropped; resp_valid_o is 0 immediately (async).

Optional Feature:
- Macro: CLINT_MTIME_HI_LATCH_EN.
- Defined:
  - A read of mtime lo snapshots mtime[63:32] into a shadow register.
  - The next read of mtime hi returns the shadow, giving a coherent 64-bit read across a lo carry.
  - Shadow reset = 0; any mtime write also updates the shadow.
- Undefined: mtime hi returns the live value; no shadow register is built.

Test Plan:
- Reset, then read mtimecmp0 lo/hi and msip0 -> 0xFFFFFFFF, 0xFFFFFFFF, 0; mtip_o=0, msip_o=0.
- TICK_DIV=4: after reset wait 40 cycles, read mtime lo -> value in 9..10; increments occur exactly every 4 clk.
- Write mtimecmp1={0,20} (NUM_HARTS=2) with mtime=0, TICK_DIV=1 -> mtip_o[1] rises 1 cycle after mtime reaches 20, mtip_o[0] stays 0; write mtimecmp1 hi=1 -> mtip_o[1] clears next cycle.
- Write msip1=0xFFFFFFFF -> reads back 0x1, msip_o=2'b10; write msip1=0 -> msip_o=0.
- Write mtime lo=0xFFFFFFFE, hi=0 -> after 2 ticks hi=1, lo=0; with CLINT_MTIME_HI_LATCH_EN, a lo read at 0xFFFFFFFF followed by a hi read after the carry returns 0.
- Read offset 0x0010 (NUM_HARTS=2) and 0x4002 -> resp_err_o=1, rdata=0, no register change; assert rst mid-request -> resp_valid_o=0 immediately.
